minicpu_sequencer: RTL and testbench
====================================

# minicpu_sequencer

Instruction sequencer that drives the MiniCPU's instruction inputs (opcode, register addresses, write data) from a small loadable program memory. It steps through the program one instruction every two cycles, holds each instruction stable for exactly one issue cycle, and captures the CPU's `alu_result` for each instruction. It sits directly in front of MiniCPU, on the same clock, and replaces hand-driven stimulus on the CPU's input pins.

## Interface
- `DEPTH`, 16: program memory entries, a power of two ≥ 2; `AW` = log2(DEPTH).
- `IDLE_OP`, 3'b000: opcode driven outside the issue cycle; must decode to `reg_write`=0 in the control unit.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `prog_we` in 1: program memory write strobe; accepted in IDLE only.
- `prog_addr` in AW: program memory write address.
- `prog_data` in 13: instruction word {opcode[12:10], wr_addr[9:8], rd_addr1[7:6], rd_addr2[5:4], wr_data[3:0]}.
- `prog_len` in AW+1: number of instructions to run (0..DEPTH); sampled on an accepted `start`.
- `start` in 1: start request; accepted in IDLE only.
- `stop` in 1: abort request; acted on in FETCH or ISSUE.
- `alu_result` in 4: result from MiniCPU.
- `opcode` out 3, `wr_addr` out 2, `rd_addr1` out 2, `rd_addr2` out 2, `wr_data` out 4: registered instruction fields to MiniCPU.
- `pc` out AW: index of the current or most recent instruction.
- `last_result` out 4: `alu_result` captured at the end of the most recent ISSUE cycle.
- `busy` out 1: high in FETCH and ISSUE.
- `done` out 1: single-cycle completion pulse.

## Operation
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - `start` with `prog_len`≠0: latch `prog_len` into `len_r`, set pc=0, go to FETCH.
  - `start` with `prog_len`=0: go to DONE.
  - `prog_we` writes `mem[prog_addr]` in any cycle spent in IDLE; it is ignored in all other states.
- FETCH: load the output field registers from `mem[pc]` and go to ISSUE. Outputs become valid on the next cycle.
- ISSUE:
  - The instruction fields are held for this one cycle; MiniCPU performs its register write on the clock edge that ends this cycle.
  - On that edge, `last_result` ← `alu_result`.
  - If pc = `len_r`−1, go to DONE; otherwise pc ← pc+1 and go to FETCH.
- DONE: `done`=1 for this cycle; next state is IDLE.
- Outside ISSUE, `opcode`=`IDLE_OP` and `wr_addr`, `rd_addr1`, `rd_addr2`, `wr_data` are all 0. The CPU therefore never sees a write during FETCH, IDLE or DONE.
- `stop` in FETCH or ISSUE:
  - Next state is IDLE; outputs return to idle values; no `done` pulse.
  - An ISSUE cycle in which `stop` is asserted still completes its CPU write and still updates `last_result`.
  - pc keeps its value.
- `start` outside IDLE and `stop` in IDLE or DONE are ignored.
- A `prog_we` in the same IDLE cycle as `start` is written; the first FETCH reads the updated memory.
- `prog_len` > DEPTH is clamped to DEPTH.
- pc arithmetic is AW bits; it never wraps within a run because the run ends at `len_r`−1.
- Program memory contents are not reset.

## Timing
- Reset values: state IDLE, pc=0, `len_r`=0, `opcode`=`IDLE_OP`, other fields 0, `last_result`=0, `busy`=0, `done`=0.
- `start` sampled at edge k:
  - FETCH during cycle k+1.
  - First ISSUE during cycle k+2.
  - Instruction n is in ISSUE during cycle k+2+2n.
- Throughput: one instruction per 2 cycles.
- `done` is high in the cycle immediately after the last ISSUE.
- `prog_len`=0: `done` is high in cycle k+1.
- `rst` asserted in any state (including mid-ISSUE) forces reset values at the next edge; a partially run program is not resumed.

## Configuration
- `MINICPU_SEQ_LOOP_EN` defined: in ISSUE, when pc = `len_r`−1, set pc ← 0 and go to FETCH instead of DONE. The program repeats until `stop` or `rst`, and `done` is never asserted for `prog_len`≠0.
- `MINICPU_SEQ_LOOP_EN` undefined: single-pass behaviour as above.
- `prog_len`=0 goes to DONE in both builds.

## Test plan
- Reset, then idle: `opcode`=3'b000, fields 0, `busy`=0, `done`=0, `last_result`=0.
- Load 3 instructions (write R1←5, write R2←3, ADD-type opcode reading R1,R2), `prog_len`=3, `start` at edge k: ISSUE cycles are k+2, k+4, k+6; `done` is high at k+7; `last_result` equals the CPU's ALU output for R1,R2 (8 for ADD); `busy` is low from k+7.
- `prog_len`=0 with `start`: `done` is high the next cycle; no ISSUE cycle; `opcode` stays 3'b000.
- `stop` asserted in the second ISSUE of a 4-instruction run: state returns to IDLE, pc=1, no `done`, the second write is still performed, and the third instruction is never driven.
- `prog_we` and `start` in FETCH: both ignored; memory is unchanged and the run proceeds normally.
- `rst` during ISSUE: outputs take reset values at the next edge. With `MINICPU_SEQ_LOOP_EN`, a 2-instruction program issues pc 0,1,0,1… every 2 cycles until `stop`, and `done` stays 0.

Source files
------------

// File: rtl/minicpu_sequencer_if.sv
// Bus between the MiniCPU instruction sequencer and its environment: program load,
// run control, and the instruction fields/result exchanged with the CPU.
interface minicpu_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [12:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          stop;
  logic [3:0]    alu_result;
  logic [2:0]    opcode;
  logic [1:0]    wr_addr;
  logic [1:0]    rd_addr1;
  logic [1:0]    rd_addr2;
  logic [3:0]    wr_data;
  logic [AW-1:0] pc;
  logic [3:0]    last_result;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, stop, alu_result,
    input  opcode, wr_addr, rd_addr1, rd_addr2, wr_data, pc, last_result, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, stop, alu_result,
    output opcode, wr_addr, rd_addr1, rd_addr2, wr_data, pc, last_result, busy, done
  );
endinterface

// File: rtl/minicpu_sequencer.sv
// Steps a small loadable program into MiniCPU, one instruction per two cycles.
// Define MINICPU_SEQ_LOOP_EN to repeat the program until stop/rst instead of finishing.
module minicpu_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter logic [2:0]  IDLE_OP = 3'b000
) (
  input logic                clk,
  input logic                rst,
  minicpu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDone} state_e;

  localparam logic [12:0] IdleInstr = {IDLE_OP, 10'b0};
  localparam logic [AW:0] DepthLen  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LenOne    = (AW + 1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [12:0]   instr_q, instr_d;
  logic [3:0]    result_q, result_d;
  logic          is_last;

  logic [12:0]   mem [DEPTH];

  // Program memory is deliberately left unreset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.prog_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign is_last = ({1'b0, pc_q} == (len_q - LenOne));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    instr_d  = IdleInstr;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.prog_len != '0) begin
            len_d   = (bus.prog_len > DepthLen) ? DepthLen : bus.prog_len;
            pc_d    = '0;
            state_d = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else begin
          instr_d = mem[pc_q];
          state_d = StIssue;
        end
      end
      StIssue: begin
        // The CPU write on this edge happens regardless of stop, so capture its result too.
        result_d = bus.alu_result;
        if (bus.stop) begin
          state_d = StIdle;
        end else if (is_last) begin
`ifdef MINICPU_SEQ_LOOP_EN
          pc_d    = '0;
          state_d = StFetch;
`else
          state_d = StDone;
`endif
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      len_q    <= '0;
      instr_q  <= IdleInstr;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      instr_q  <= instr_d;
      result_q <= result_d;
    end
  end

  assign bus.opcode      = instr_q[12:10];
  assign bus.wr_addr     = instr_q[9:8];
  assign bus.rd_addr1    = instr_q[7:6];
  assign bus.rd_addr2    = instr_q[5:4];
  assign bus.wr_data     = instr_q[3:0];
  assign bus.pc          = pc_q;
  assign bus.last_result = result_q;
  assign bus.busy        = (state_q == StFetch) || (state_q == StIssue);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_minicpu_sequencer.sv
// Scoreboard bench for minicpu_sequencer with a tiny MiniCPU stand-in (opcode 1 = load
// immediate, opcode 2 = add). With MINICPU_SEQ_LOOP_EN defined only the loop run is exercised.
module tb_minicpu_sequencer;
  localparam int unsigned AW = 4;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [12:0] word;
    logic [3:0]  pc;
    logic [3:0]  res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   ks;
  exp_t sb[$];
  exp_t e;
  logic [3:0] rf [4];

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  minicpu_sequencer_if #(.AW(AW)) bus ();

  minicpu_sequencer #(
    .DEPTH  (16),
    .AW     (AW),
    .IDLE_OP(3'b000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // CPU stand-in driven by the sequencer outputs.
  always_comb begin
    case (bus.opcode)
      3'b001:  bus.alu_result = bus.wr_data;
      3'b010:  bus.alu_result = rf[bus.rd_addr1] + rf[bus.rd_addr2];
      default: bus.alu_result = 4'd0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
    end else if (bus.opcode == 3'b001 || bus.opcode == 3'b010) begin
      rf[bus.wr_addr] <= bus.alu_result;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  // Monitor: every issued instruction and every done pulse must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.opcode !== 3'b000) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got pc %0d at cycle %0d expected nothing", bus.pc, cnt);
        end else begin
          e = sb.pop_front();
          chk("issue_kind", {31'd0, e.is_done}, 32'd0);
          chk("issue_cycle", cnt, e.cyc);
          chk("issue_word", {19'd0, bus.opcode, bus.wr_addr, bus.rd_addr1, bus.rd_addr2,
                             bus.wr_data}, {19'd0, e.word});
          chk("issue_pc", {28'd0, bus.pc}, {28'd0, e.pc});
        end
      end
      if (bus.done !== 1'b0) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d expected nothing", cnt);
        end else begin
          e = sb.pop_front();
          chk("done_kind", {31'd0, e.is_done}, 32'd1);
          chk("done_cycle", cnt, e.cyc);
          chk("done_result", {28'd0, bus.last_result}, {28'd0, e.res});
          chk("done_busy", {31'd0, bus.busy}, 32'd0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int a, input logic [12:0] w);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(a);
    bus.prog_data = w;
    tick(1);
    bus.prog_we   = 1'b0;
  endtask

  // Drives start for the coming edge; ks is the count value right after that edge.
  task automatic arm(input int len, output int k);
    bus.prog_len = (AW + 1)'(len);
    bus.start    = 1'b1;
    k            = cnt + 1;
  endtask

  task automatic exp_issue(input int cyc, input logic [12:0] w, input int p);
    exp_t x;
    x.is_done = 1'b0;
    x.cyc     = cyc;
    x.word    = w;
    x.pc      = 4'(p);
    x.res     = 4'd0;
    sb.push_back(x);
  endtask

  task automatic exp_done(input int cyc, input logic [3:0] r);
    exp_t x;
    x.is_done = 1'b1;
    x.cyc     = cyc;
    x.word    = 13'd0;
    x.pc      = 4'd0;
    x.res     = r;
    sb.push_back(x);
  endtask

  initial begin
    logic [12:0] w;
    rst           = 1'b1;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    tick(3);
    chk("rst_opcode", {29'd0, bus.opcode}, 32'd0);
    chk("rst_fields", {22'd0, bus.wr_addr, bus.rd_addr1, bus.rd_addr2, bus.wr_data}, 32'd0);
    chk("rst_pc", {28'd0, bus.pc}, 32'd0);
    chk("rst_last_result", {28'd0, bus.last_result}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    tick(1);
    mon_en = 1'b1;

`ifdef MINICPU_SEQ_LOOP_EN
    // R1<-4, then R2<-R1+R1 (8), repeated until stop.
    load(0, 13'b001_01_00_00_0100);
    load(1, 13'b010_10_01_01_0000);
    arm(2, ks);
    for (int i = 0; i < 6; i++) begin
      exp_issue(ks + 1 + 2 * i, (i % 2 == 0) ? 13'b001_01_00_00_0100 : 13'b010_10_01_01_0000,
                i % 2);
    end
    tick(1);
    bus.start = 1'b0;
    tick(11);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("loop_busy", {31'd0, bus.busy}, 32'd0);
    chk("loop_pc", {28'd0, bus.pc}, 32'd1);
    chk("loop_last_result", {28'd0, bus.last_result}, 32'd8);
    tick(4);
    chk("loop_queue_empty", sb.size(), 32'd0);
`else
    // Three-instruction run: R1<-5, R2<-3, R3<-R1+R2 (8); start/prog_we during FETCH ignored.
    load(0, 13'b001_01_00_00_0101);
    load(1, 13'b001_10_00_00_0011);
    load(2, 13'b010_11_01_10_0000);
    arm(3, ks);
    exp_issue(ks + 1, 13'b001_01_00_00_0101, 0);
    exp_issue(ks + 3, 13'b001_10_00_00_0011, 1);
    exp_issue(ks + 5, 13'b010_11_01_10_0000, 2);
    exp_done(ks + 6, 4'd8);
    tick(1);
    bus.start     = 1'b1;
    bus.prog_len  = 5'd1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd2;
    bus.prog_data = 13'h1fff;
    tick(1);
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    tick(7);
    chk("run3_queue_empty", sb.size(), 32'd0);
    chk("run3_r3", {28'd0, rf[3]}, 32'd8);

    // Zero-length run: immediate done, last_result unchanged, nothing issued.
    arm(0, ks);
    exp_done(ks, 4'd8);
    tick(1);
    bus.start = 1'b0;
    tick(3);
    chk("len0_queue_empty", sb.size(), 32'd0);

    // Oversized prog_len clamps to 16 entries.
    for (int i = 0; i < 16; i++) begin
      w = {3'b001, 2'(i), 4'b0000, 4'(i)};
      load(i, w);
    end
    arm(20, ks);
    for (int i = 0; i < 16; i++) begin
      w = {3'b001, 2'(i), 4'b0000, 4'(i)};
      exp_issue(ks + 1 + 2 * i, w, i);
    end
    exp_done(ks + 32, 4'd15);
    tick(1);
    bus.start = 1'b0;
    tick(34);
    chk("clamp_queue_empty", sb.size(), 32'd0);

    // Stop during the second ISSUE of a four-instruction run.
    load(0, 13'b001_01_00_00_0111);
    load(1, 13'b001_10_00_00_1001);
    load(2, 13'b010_11_01_10_0000);
    load(3, 13'b001_00_00_00_1111);
    arm(4, ks);
    exp_issue(ks + 1, 13'b001_01_00_00_0111, 0);
    exp_issue(ks + 3, 13'b001_10_00_00_1001, 1);
    tick(1);
    bus.start = 1'b0;
    tick(3);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("stop_busy", {31'd0, bus.busy}, 32'd0);
    chk("stop_pc", {28'd0, bus.pc}, 32'd1);
    chk("stop_last_result", {28'd0, bus.last_result}, 32'd9);
    chk("stop_r2_written", {28'd0, rf[2]}, 32'd9);
    chk("stop_opcode", {29'd0, bus.opcode}, 32'd0);
    tick(6);
    chk("stop_queue_empty", sb.size(), 32'd0);

    // Reset during the first ISSUE; the run must not resume.
    arm(4, ks);
    exp_issue(ks + 1, 13'b001_01_00_00_0111, 0);
    tick(1);
    bus.start = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rsti_opcode", {29'd0, bus.opcode}, 32'd0);
    chk("rsti_busy", {31'd0, bus.busy}, 32'd0);
    chk("rsti_pc", {28'd0, bus.pc}, 32'd0);
    chk("rsti_last_result", {28'd0, bus.last_result}, 32'd0);
    chk("rsti_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    tick(8);
    chk("rsti_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("rsti_queue_empty", sb.size(), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
